// File: rtl/risc_pkg.sv
// risc_pkg: shared widths, opcode constants and r0 handling default for the pipeline
package risc_pkg;
  localparam int DATA_WIDTH = 16;
  localparam int REG_ADDR_WIDTH = 3;
  localparam int OP_WIDTH = 4;
  localparam bit R0_ZERO_DEFAULT = 1'b0;
  typedef enum logic [OP_WIDTH-1:0] {
    OP_ADD = 4'h0,
    OP_SUB = 4'h1,
    OP_AND = 4'h2,
    OP_OR  = 4'h3,
    OP_XOR = 4'h4,
    OP_LD  = 4'h8,
    OP_ST  = 4'h9,
    OP_BEQ = 4'hC
  } op_e;
endpackage

// File: rtl/operand_bypass_mux.sv
// operand_bypass_mux: picks one source operand from r0 zero, EX bypass, WB bypass or register file
module operand_bypass_mux #(
  parameter int DATA_WIDTH = risc_pkg::DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = risc_pkg::REG_ADDR_WIDTH,
  parameter bit R0_ZERO = risc_pkg::R0_ZERO_DEFAULT
) (
  input  logic [REG_ADDR_WIDTH-1:0] rs,
  input  logic [DATA_WIDTH-1:0]     rf_value,
  input  logic                      ex_valid,
  input  logic                      ex_load,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  input  logic [DATA_WIDTH-1:0]     ex_value,
  input  logic                      wb_valid,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
  input  logic [DATA_WIDTH-1:0]     wb_value,
  output logic [DATA_WIDTH-1:0]     value
);
  always_comb begin
    value = (R0_ZERO && rs == '0) ? '0 :
            (ex_valid && !ex_load && ex_rd == rs) ? ex_value :
            (wb_valid && wb_rd == rs) ? wb_value : rf_value;
  end
endmodule

// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage: ID/EX operand select with bypassing, load-use stall and valid/ready pipeline register
module operand_fetch_stage #(
  parameter int DATA_WIDTH = risc_pkg::DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = risc_pkg::REG_ADDR_WIDTH,
  parameter int OP_WIDTH = risc_pkg::OP_WIDTH,
  parameter bit R0_ZERO = risc_pkg::R0_ZERO_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [15:0]               in_pc,
  input  logic [OP_WIDTH-1:0]       in_op,
  input  logic [REG_ADDR_WIDTH-1:0] in_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] in_rs2,
  input  logic                      in_use_rs1,
  input  logic                      in_use_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] in_rd,
  input  logic                      in_reg_write,
  input  logic                      in_mem_read,
  input  logic [DATA_WIDTH-1:0]     in_imm,
  output logic [REG_ADDR_WIDTH-1:0] rf_rs1,
  output logic [REG_ADDR_WIDTH-1:0] rf_rs2,
  input  logic [DATA_WIDTH-1:0]     rf_rs1_value,
  input  logic [DATA_WIDTH-1:0]     rf_rs2_value,
  input  logic                      ex_fwd_valid,
  input  logic [REG_ADDR_WIDTH-1:0] ex_fwd_rd,
  input  logic [DATA_WIDTH-1:0]     ex_fwd_value,
  input  logic                      ex_fwd_load,
  input  logic                      wb_fwd_valid,
  input  logic [REG_ADDR_WIDTH-1:0] wb_fwd_rd,
  input  logic [DATA_WIDTH-1:0]     wb_fwd_value,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [15:0]               out_pc,
  output logic [OP_WIDTH-1:0]       out_op,
  output logic [REG_ADDR_WIDTH-1:0] out_rd,
  output logic                      out_reg_write,
  output logic                      out_mem_read,
  output logic [DATA_WIDTH-1:0]     out_imm,
  output logic [DATA_WIDTH-1:0]     out_a,
  output logic [DATA_WIDTH-1:0]     out_b,
  output logic [15:0]               stall_count
);
  logic hit1, hit2, hazard, xfer;
  logic [DATA_WIDTH-1:0] a, b;
  assign rf_rs1 = in_rs1;
  assign rf_rs2 = in_rs2;
  always_comb begin
    hit1 = in_use_rs1 && ex_fwd_rd == in_rs1 && !(R0_ZERO && in_rs1 == '0);
    hit2 = in_use_rs2 && ex_fwd_rd == in_rs2 && !(R0_ZERO && in_rs2 == '0);
    hazard = ex_fwd_valid && ex_fwd_load && (hit1 || hit2);
    in_ready = (!out_valid || out_ready) && !hazard && !flush;
    xfer = in_valid && in_ready;
  end
  operand_bypass_mux #(
    .DATA_WIDTH(DATA_WIDTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH), .R0_ZERO(R0_ZERO)
  ) mux_a (
    .rs(in_rs1), .rf_value(rf_rs1_value),
    .ex_valid(ex_fwd_valid), .ex_load(ex_fwd_load), .ex_rd(ex_fwd_rd), .ex_value(ex_fwd_value),
    .wb_valid(wb_fwd_valid), .wb_rd(wb_fwd_rd), .wb_value(wb_fwd_value),
    .value(a)
  );
  operand_bypass_mux #(
    .DATA_WIDTH(DATA_WIDTH), .REG_ADDR_WIDTH(REG_ADDR_WIDTH), .R0_ZERO(R0_ZERO)
  ) mux_b (
    .rs(in_rs2), .rf_value(rf_rs2_value),
    .ex_valid(ex_fwd_valid), .ex_load(ex_fwd_load), .ex_rd(ex_fwd_rd), .ex_value(ex_fwd_value),
    .wb_valid(wb_fwd_valid), .wb_rd(wb_fwd_rd), .wb_value(wb_fwd_value),
    .value(b)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_pc <= '0;
      out_op <= '0;
      out_rd <= '0;
      out_reg_write <= 1'b0;
      out_mem_read <= 1'b0;
      out_imm <= '0;
      out_a <= '0;
      out_b <= '0;
      stall_count <= '0;
    end else begin
      if (in_valid && hazard && !flush && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
      if (flush) out_valid <= 1'b0;
      else if (xfer) begin
        out_valid <= 1'b1;
        out_pc <= in_pc;
        out_op <= in_op;
        out_rd <= in_rd;
        out_reg_write <= in_reg_write;
        out_mem_read <= in_mem_read;
        out_imm <= in_imm;
        out_a <= a;
        out_b <= b;
      end else if (out_ready) out_valid <= 1'b0;
    end
  end
endmodule
